// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// Handshake: fe_en/fe_pc are held by the fetch unit until a one-cycle fe_hit returns; mc_en/mc_pc are held by the cache until a one-cycle mc_done returns.
interface icache_if;
  logic        fe_en;
  logic [31:0] fe_pc;
  logic        fe_hit;
  logic [31:0] fe_inst;
  logic        mc_en;
  logic [31:0] mc_pc;
  logic        mc_done;
  logic [31:0] mc_data;

  modport slave (
    input  fe_en, fe_pc, mc_done, mc_data,
    output fe_hit, fe_inst, mc_en, mc_pc
  );

  modport master (
    output fe_en, fe_pc, mc_done, mc_data,
    input  fe_hit, fe_inst, mc_en, mc_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Cancelled misses still install their fill, since the memory fetch cannot be aborted.
module icache #(
  parameter int IDX_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rollback,
  icache_if.slave  bus,
  output logic     dbg_state
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        fe_hit_q, fe_hit_d;
  logic [31:0] fe_inst_q, fe_inst_d;
  logic        mc_en_q, mc_en_d;
  logic [29:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic        fill_we;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] fe_idx, req_idx;
  logic [TAG_W-1:0] fe_tag, req_tag;
  logic             lookup_hit;

  assign fe_idx     = bus.fe_pc[IDX_W+1:2];
  assign fe_tag     = bus.fe_pc[31:IDX_W+2];
  assign req_idx    = req_pc_q[IDX_W-1:0];
  assign req_tag    = req_pc_q[29:IDX_W];
  assign lookup_hit = valid_q[fe_idx] && (tag_mem[fe_idx] == fe_tag);

  assign bus.fe_hit  = fe_hit_q;
  assign bus.fe_inst = fe_inst_q;
  assign bus.mc_en   = mc_en_q;
  assign bus.mc_pc   = {req_pc_q, 2'b00};
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    fe_hit_d  = 1'b0;
    fe_inst_d = fe_inst_q;
    mc_en_d   = mc_en_q;
    req_pc_d  = req_pc_q;
    cancel_d  = cancel_q;
    fill_we   = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.fe_en && !rollback) begin
            if (lookup_hit) begin
              fe_hit_d  = 1'b1;
              fe_inst_d = data_mem[fe_idx];
            end else begin
              req_pc_d = bus.fe_pc[31:2];
              mc_en_d  = 1'b1;
              cancel_d = 1'b0;
              state_d  = MISS;
            end
          end
        end
        MISS: begin
          // fe_en is ignored here, so a fill never races a lookup.
          if (rollback) cancel_d = 1'b1;
          if (bus.mc_done) begin
            fill_we = 1'b1;
            mc_en_d = 1'b0;
            state_d = IDLE;
            if (!cancel_q && !rollback) begin
              fe_hit_d  = 1'b1;
              fe_inst_d = bus.mc_data;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fe_hit_q  <= 1'b0;
      fe_inst_q <= '0;
      mc_en_q   <= 1'b0;
      req_pc_q  <= '0;
      cancel_q  <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      fe_hit_q  <= fe_hit_d;
      fe_inst_q <= fe_inst_d;
      mc_en_q   <= mc_en_d;
      req_pc_q  <= req_pc_d;
      cancel_q  <= cancel_d;
      if (fill_we) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus.mc_data;
    end
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, single-word-line instruction cache between the instruction-fetch unit and the memory controller's instruction-fetch port. Hits return one 32-bit instruction the cycle after the request. Misses issue one 4-byte fetch to the memory controller, fill the line, and forward the word. Rollback cancels delivery of a pending miss, but the in-flight fill still completes and is installed.

## Interface
- IDX_W, default 6: index width; the cache has 2^IDX_W lines of one 32-bit word each.
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2] (30-IDX_W bits); pc[1:0] ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  pipeline flush; cancels the current or pending request.
- fe_en  in  1  fetch request valid.
- fe_pc  in  32  fetch address.
- fe_hit  out  1  one-cycle pulse: fe_inst is valid for the last accepted request.
- fe_inst  out  32  instruction word (byte 0 at bits [7:0]).
- mc_en  out  1  fetch request to the memory controller, held until mc_done.
- mc_pc  out  32  word-aligned fetch address, {pc[31:2],2'b00}.
- mc_done  in  1  one-cycle pulse from the memory controller: mc_data is valid.
- mc_data  in  32  fetched word (little-endian).

## Operation
- Storage: valid[2^IDX_W], tag array, data array. Valid bits are cleared only by rst; there is no other invalidate.
- Registers: state, req_pc, cancel.
- States: IDLE, MISS.
- IDLE, request accepted (fe_en=1, rollback=0, rdy=1):
  - Look up at index(fe_pc).
  - Hit (valid && tag match): fe_hit<=1, fe_inst<=data; stay in IDLE.
  - Miss: fe_hit<=0, req_pc<=fe_pc, mc_pc<={fe_pc[31:2],2'b00}, mc_en<=1, cancel<=0, go to MISS.
- IDLE, any other case: fe_hit<=0. A request with rollback=1 in the same cycle is dropped.
- MISS:
  - fe_en is ignored.
  - mc_en stays 1 and mc_pc stays stable until mc_done.
  - rollback=1 while in MISS sets cancel<=1.
  - On mc_done: write valid=1, tag(req_pc) and mc_data at index(req_pc); mc_en<=0; go to IDLE.
  - Also on mc_done: if cancel=0 and rollback=0, fe_hit<=1 and fe_inst<=mc_data; otherwise fe_hit<=0.
- The fill is always installed, even when cancelled. The memory controller's instruction fetch cannot be aborted, so its data is still correct for that address.
- Each accepted, uncancelled request yields exactly one fe_hit.
- Fetch unit handshake: while waiting for fe_hit it holds fe_pc stable and keeps fe_en asserted.
- When rollback coincides with fe_hit=1, the fetch unit discards that instruction; the cache takes no action.
- Cache updates: a same-cycle fill and lookup cannot occur, because fe_en is ignored in MISS.

## Timing
- Reset values: fe_hit=0, fe_inst=0, mc_en=0, mc_pc=0, state=IDLE, cancel=0, all valid=0.
- rdy=0: state, arrays and mc_en/mc_pc hold; fe_hit<=0. The memory controller holds mc_done at 0 during !rdy.
- Hit latency: request in cycle T, fe_hit=1 in T+1. Back-to-back hits give one instruction per cycle.
- Miss latency: request in T; mc_en=1 from T+1; mc_done in cycle D; fe_hit=1 in D+1; mc_en=0 from D+1.
  - The memory controller bubbles for one cycle after done, so deasserting mc_en in D+1 creates no duplicate fetch.
  - The earliest new request is accepted in D+1.
- mc_en must not be raised in the cycle after mc_done for the same address. The IDLE-after-MISS request path must itself be a valid new fetch.
- rst in MISS: return to IDLE, clear all valid bits, mc_en=0. A late mc_done after reset is ignored, since it arrives in IDLE.

## Test plan
- Reset: hold rst for 3 cycles -> all outputs 0; first fe_pc=0x0 -> mc_en=1 with mc_pc=0x0 (cold miss).
- Cold miss then hit:
  - fe_pc=0x4; model returns mc_data=0x00500093 after 5 cycles -> fe_hit pulses with fe_inst=0x00500093 in the cycle after mc_done.
  - Re-request 0x4 -> fe_hit in 1 cycle with mc_en staying 0.
- Conflict miss (IDX_W=6):
  - Fill 0x000 with 0x11111111, then request 0x100 (same index, tag 1) -> miss, fill 0x22222222.
  - Then 0x000 -> miss again; fe_inst=0x11111111 after refill.
- Rollback during miss:
  - Miss on 0x8, assert rollback for 1 cycle mid-fetch -> mc_en held until mc_done and no fe_hit.
  - Subsequent request 0x8 -> hit in 1 cycle with the filled data.
- rdy stall: drop rdy for 4 cycles during MISS and during a hit -> mc_en/mc_pc hold, fe_hit=0 while rdy=0, request completes normally after rdy returns.
- Back-to-back hits: preload 0x0, 0x4, 0x8, 0xC; issue consecutive requests each cycle -> four consecutive fe_hit pulses with matching words, mc_en never asserted.
